// File: rtl/multdiv_sequencer_pkg.sv
// Shared types and constants for the multdiv sequencer: FSM encoding,
// exception codes, request record and the mult/div decode constants.
package multdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } md_state_e;

  localparam logic [31:0] EXC_NONE        = 32'd0;
  localparam logic [31:0] EXC_MULT        = 32'd4;
  localparam logic [31:0] EXC_DIV         = 32'd5;
  localparam logic [31:0] EXC_TIMEOUT_DEF = 32'd7;

  localparam logic [4:0] OPC_ALU    = 5'b00000;
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  typedef struct packed {
    logic        is_div;
    logic [4:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
  } md_req_t;

  // Decode helper for the execute stage that generates op_valid.
  function automatic logic is_multdiv_op(input logic [4:0] opcode,
                                         input logic [4:0] aluop);
    return (opcode == OPC_ALU) && ((aluop == ALUOP_MULT) || (aluop == ALUOP_DIV));
  endfunction

  function automatic logic [31:0] md_exc_code(input logic exc, input logic is_div);
    if (!exc)   return EXC_NONE;
    if (is_div) return EXC_DIV;
    return EXC_MULT;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Execute-stage / multdiv-unit bundle seen by the sequencer.
interface multdiv_sequencer_if;
  logic        op_valid;
  logic        op_is_div;
  logic [4:0]  op_tag;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        md_result_rdy;
  logic [31:0] md_result;
  logic        md_exception;

  logic        md_start_mult;
  logic        md_start_div;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  result_tag;
  logic [31:0] exc_code;

  modport slave (
    input  op_valid, op_is_div, op_tag, operand_a, operand_b, flush,
           md_result_rdy, md_result, md_exception,
    output md_start_mult, md_start_div, md_operand_a, md_operand_b, stall,
           result_valid, result, result_tag, exc_code
  );

  modport master (
    output op_valid, op_is_div, op_tag, operand_a, operand_b, flush,
           md_result_rdy, md_result, md_exception,
    input  md_start_mult, md_start_div, md_operand_a, md_operand_b, stall,
           result_valid, result, result_tag, exc_code
  );
endinterface

// File: rtl/multdiv_sequencer_md_cycle_counter.sv
// Saturating up-counter with synchronous clear, used as the BUSY timeout clock.
module md_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/multdiv_sequencer.sv
// Drives the shared multdiv unit for the execute stage: latch request, one
// start pulse, wait for ready (with timeout), report result and hold stall.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int          MAX_CYCLES  = 40,
  parameter int          CNT_W       = 6,
  parameter logic [31:0] TIMEOUT_EXC = EXC_TIMEOUT_DEF
) (
  input logic                clk_i,
  input logic                rst_ni,
  multdiv_sequencer_if.slave bus
);
  md_state_e        state_q;
  md_req_t          req_q;
  logic             start_mult_q, start_div_q, rv_q;
  logic [31:0]      result_q, exc_q;
  logic [4:0]       tag_q;
  logic [CNT_W-1:0] cnt;
  logic             timeout, accept, stall_c;

  md_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q == S_START),
    .en_i   (state_q == S_BUSY),
    .cnt_o  (cnt)
  );

  assign timeout = (cnt == CNT_W'(MAX_CYCLES - 1));
  assign accept  = bus.op_valid && !bus.flush;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      rv_q         <= 1'b0;
      result_q     <= '0;
      exc_q        <= '0;
      tag_q        <= '0;
    end else begin
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      rv_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_q        <= '{is_div: bus.op_is_div, tag: bus.op_tag,
                              a: bus.operand_a, b: bus.operand_b};
            start_mult_q <= !bus.op_is_div;
            start_div_q  <= bus.op_is_div;
            state_q      <= S_START;
          end
        end
        S_START: state_q <= bus.flush ? S_IDLE : S_BUSY;
        S_BUSY: begin
          // Flush beats completion; ready beats timeout.
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else if (bus.md_result_rdy) begin
            result_q <= bus.md_result;
            exc_q    <= md_exc_code(bus.md_exception, req_q.is_div);
            tag_q    <= req_q.tag;
            rv_q     <= 1'b1;
            state_q  <= S_DONE;
          end else if (timeout) begin
            result_q <= '0;
            exc_q    <= TIMEOUT_EXC;
            tag_q    <= req_q.tag;
            rv_q     <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        // op_valid here is the instruction just completed; never re-accept it.
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_c = 1'b0;
    case (state_q)
      S_IDLE:          stall_c = accept;
      S_START, S_BUSY: stall_c = !bus.flush;
      default:         stall_c = 1'b0;
    endcase
  end

  assign bus.stall         = stall_c && rst_ni;
  assign bus.md_start_mult = start_mult_q;
  assign bus.md_start_div  = start_div_q;
  assign bus.md_operand_a  = req_q.a;
  assign bus.md_operand_b  = req_q.b;
  assign bus.result_valid  = rv_q;
  assign bus.result        = result_q;
  assign bus.result_tag    = tag_q;
  assign bus.exc_code      = exc_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench: the bench plays the multdiv unit and the execute stage.
module tb_multdiv_sequencer;
  localparam int MAXC = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multdiv_sequencer_if bus();

  multdiv_sequencer #(.MAX_CYCLES(MAXC), .CNT_W(6), .TIMEOUT_EXC(32'd7)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic [31:0] exc;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, rv_cnt = 0, st_cnt = 0, rv_cyc_last = 0, rv_cyc_prev = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every result pulse.
  always @(negedge clk) begin
    if (bus.md_start_mult || bus.md_start_div) st_cnt++;
    if (bus.result_valid) begin
      rv_cnt++;
      rv_cyc_prev = rv_cyc_last;
      rv_cyc_last = cyc;
      if (sb.size() == 0) begin
        chk("spurious_rv", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("result_tag", bus.result_tag, e.tag);
        chk("exc_code", bus.exc_code, e.exc);
      end
    end
  end

  // Caller is at posedge+#1 on entry and exit. k: BUSY index where rdy is
  // driven (-1 = never). fl: BUSY index where flush is driven (-1 = never).
  task automatic op(input logic dv, input logic [4:0] tg, input logic [31:0] a,
                    input logic [31:0] b, input int k, input logic ex, input int fl);
    logic [31:0] mres;
    exp_t e;
    mres = dv ? ((b == 0) ? 32'hFFFF_FFFF : a / b) : a * b;
    bus.op_valid  = 1'b1;
    bus.op_is_div = dv;
    bus.op_tag    = tg;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk); chk("accept_stall", bus.stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("start_mult", bus.md_start_mult, !dv);
    chk("start_div", bus.md_start_div, dv);
    chk("md_operand_a", bus.md_operand_a, a);
    chk("md_operand_b", bus.md_operand_b, b);
    chk("start_stall", bus.stall, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < MAXC + 10; i++) begin
      if (i == fl) begin
        bus.flush = 1'b1;
        @(negedge clk); chk("flush_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        return;
      end
      if (i == k) begin
        bus.md_result_rdy = 1'b1;
        bus.md_result     = mres;
        bus.md_exception  = ex;
        e.res = mres; e.tag = tg; e.exc = ex ? (dv ? 32'd5 : 32'd4) : 32'd0;
        sb.push_back(e);
      end else if (k < 0 && i == MAXC - 1) begin
        e.res = 32'd0; e.tag = tg; e.exc = 32'd7;
        sb.push_back(e);
      end
      @(negedge clk);
      chk("busy_stall", bus.stall, 1'b1);
      chk("busy_no_rv", bus.result_valid, 1'b0);
      @(posedge clk); #1;
      bus.md_result_rdy = 1'b0;
      bus.md_exception  = 1'b0;
      if (i == k || (k < 0 && i == MAXC - 1)) break;
    end
    @(negedge clk);
    chk("done_rv", bus.result_valid, 1'b1);
    chk("done_stall", bus.stall, 1'b0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  initial begin
    int rv0, st0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv0, st0;
    bus.op_valid = 0; bus.op_is_div = 0; bus.op_tag = 0;
    bus.operand_a = 0; bus.operand_b = 0; bus.flush = 0;
    bus.md_result_rdy = 0; bus.md_result = 0; bus.md_exception = 0;

    #12;
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_rv", bus.result_valid, 1'b0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_exc", bus.exc_code, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: mult 7*6, rdy in 3rd BUSY cycle
    rv0 = rv_cnt; st0 = st_cnt;
    op(1'b0, 5'd3, 32'd7, 32'd6, 2, 1'b0, -1);
    chk("t1_result", bus.result, 32'd42);
    chk("t1_starts", st_cnt - st0, 1);
    chk("t1_rvs", rv_cnt - rv0, 1);

    // 2: div by zero with exception
    op(1'b1, 5'd9, 32'd100, 32'd0, 0, 1'b1, -1);
    chk("t2_exc", bus.exc_code, 32'd5);
    @(negedge clk); chk("t2_rv_pulse", bus.result_valid, 1'b0);
    @(posedge clk); #1;

    // 3: flush in 2nd BUSY cycle, next op straight after
    rv0 = rv_cnt;
    op(1'b0, 5'd4, 32'd2, 32'd3, 5, 1'b0, 1);
    chk("t3_rv_none", rv_cnt - rv0, 0);
    chk("t3_exc_hold", bus.exc_code, 32'd5);
    op(1'b0, 5'd6, 32'd3, 32'd4, 0, 1'b0, -1);
    chk("t3_next", bus.result, 32'd12);

    // 4: timeout
    bus.md_result = 32'h1234_5678;
    op(1'b0, 5'd7, 32'd11, 32'd13, -1, 1'b0, -1);
    chk("t4_exc", bus.exc_code, 32'd7);
    chk("t4_result", bus.result, 32'd0);

    // rdy coincides with timeout: rdy wins
    op(1'b0, 5'd8, 32'd6, 32'd7, MAXC - 1, 1'b0, -1);
    chk("tc_exc", bus.exc_code, 32'd0);

    // 5: back-to-back
    rv0 = rv_cnt; st0 = st_cnt;
    op(1'b0, 5'd1, 32'd3, 32'd3, 0, 1'b0, -1);
    op(1'b0, 5'd2, 32'd5, 32'd5, 0, 1'b0, -1);
    chk("t5_spacing", rv_cyc_last - rv_cyc_prev, 4);
    chk("t5_starts", st_cnt - st0, 2);
    chk("t5_result", bus.result, 32'd25);

    // 6: reset mid-BUSY, then stale rdy
    bus.op_valid = 1'b1; bus.op_is_div = 1'b1; bus.op_tag = 5'd12;
    bus.operand_a = 32'd50; bus.operand_b = 32'd5;
    repeat (3) begin @(posedge clk); #1; end
    bus.op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_stall", bus.stall, 1'b0);
    chk("t6_rv", bus.result_valid, 1'b0);
    chk("t6_result", bus.result, 32'd0);
    chk("t6_tag", bus.result_tag, 5'd0);
    chk("t6_exc", bus.exc_code, 32'd0);
    chk("t6_opa", bus.md_operand_a, 32'd0);
    chk("t6_start", {bus.md_start_mult, bus.md_start_div}, 2'b00);
    @(posedge clk); #1; rst_n = 1'b1;
    bus.md_result_rdy = 1'b1; bus.md_result = 32'd99;
    rv0 = rv_cnt;
    repeat (3) begin
      @(negedge clk);
      chk("t6_stale_stall", bus.stall, 1'b0);
    end
    @(posedge clk); #1; bus.md_result_rdy = 1'b0;
    @(negedge clk);
    chk("t6_stale_rv", rv_cnt - rv0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
